// File: rtl/mul_issue_ctrl.sv
// Issue/retire sequencer for the 2-stage MUL unit: extends operands, gates issue on response
// credit, tracks in-flight metadata in order and buffers results in a response FIFO.
module mul_issue_ctrl #(
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned MUL_LAT    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             mul_in_valid,
    input  logic             mul_in_ready,
    output logic [32:0]      mul_src1,
    output logic [32:0]      mul_src2,
    input  logic             mul_out_valid,
    input  logic [63:0]      mul_result
);

    // Accept at edge N retires at edge N+3, so one more op than MUL_LAT can be outstanding.
    localparam int unsigned MetaDepth = MUL_LAT + 1;
    localparam int unsigned MetaPtrW  = $clog2(MetaDepth);
    localparam int unsigned IfW       = $clog2(MetaDepth + 1);
    localparam int unsigned CntW      = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PtrW      = $clog2(RESP_DEPTH);

    logic                w_ext_a;
    logic                w_ext_b;
    logic                w_can_issue;
    logic                w_accept;
    logic                w_retire;
    logic                w_fifo_rd;
    logic [31:0]         w_sel_data;

    logic [TAG_W:0]      r_meta [MetaDepth];
    logic [MetaPtrW-1:0] r_meta_wr;
    logic [MetaPtrW-1:0] r_meta_rd;
    logic [IfW-1:0]      r_inflight;

    logic [31:0]         r_fifo_data [RESP_DEPTH];
    logic [TAG_W-1:0]    r_fifo_tag  [RESP_DEPTH];
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [CntW-1:0]     r_count;

    function automatic logic [MetaPtrW-1:0] meta_next(input logic [MetaPtrW-1:0] p);
        return (p == MetaPtrW'(MetaDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_ext_a  = req_a[31] & ((req_op == 2'b01) | (req_op == 2'b10));
    assign w_ext_b  = req_b[31] & (req_op == 2'b01);
    assign mul_src1 = {w_ext_a, req_a};
    assign mul_src2 = {w_ext_b, req_b};

    assign w_can_issue  = (32'(r_inflight) + 32'(r_count)) < RESP_DEPTH;
    assign req_ready    = mul_in_ready & w_can_issue & ~reset;
    assign mul_in_valid = req_valid & req_ready;
    assign w_accept     = mul_in_valid;

    // Strobes seen with nothing in flight are leftovers from before a reset.
    assign w_retire   = mul_out_valid & (r_inflight != '0);
    assign w_fifo_rd  = (r_count != '0) & resp_ready;
    assign w_sel_data = r_meta[r_meta_rd][TAG_W] ? mul_result[63:32] : mul_result[31:0];

    assign resp_valid = (r_count != '0);
    assign resp_data  = r_fifo_data[r_rd_ptr];
    assign resp_tag   = r_fifo_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MetaDepth); i++) r_meta[i] <= '0;
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_tag[i]  <= '0;
            end
            r_meta_wr  <= '0;
            r_meta_rd  <= '0;
            r_inflight <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_meta[r_meta_wr] <= {req_op != 2'b00, req_tag};
                r_meta_wr         <= meta_next(r_meta_wr);
            end
            if (w_retire) begin
                r_meta_rd             <= meta_next(r_meta_rd);
                r_fifo_data[r_wr_ptr] <= w_sel_data;
                r_fifo_tag[r_wr_ptr]  <= r_meta[r_meta_rd][TAG_W-1:0];
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            case ({w_retire, w_fifo_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_retire && !w_fifo_rd && (r_count == CntW'(RESP_DEPTH))));
            assert (!(w_accept && !w_retire && (r_inflight == IfW'(MetaDepth))));
        end
    end

endmodule
